// File: rtl/y_mux_4to1.sv
// Parameterised 4-to-1 word multiplexer built as a two-level tree of 2-to-1 muxes.
// Define YMUX4TO1_REG_EN to register z into z_q; otherwise z_q is wired straight to z.
module y_mux_4to1 #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] a0,
    input  logic [SIZE-1:0] a1,
    input  logic [SIZE-1:0] a2,
    input  logic [SIZE-1:0] a3,
    input  logic [1:0]      c,
    output logic [SIZE-1:0] z,
    output logic [SIZE-1:0] z_q
);

    // AND/OR form keeps an unknown select visible as X wherever the candidates differ.
    function automatic logic [SIZE-1:0] mux2(input logic [SIZE-1:0] a,
                                             input logic [SIZE-1:0] b,
                                             input logic            s);
        return (a & ~{SIZE{s}}) | (b & {SIZE{s}});
    endfunction

    logic [SIZE-1:0] lo;
    logic [SIZE-1:0] hi;

    assign lo = mux2(a0, a1, c[0]);
    assign hi = mux2(a2, a3, c[0]);
    assign z  = mux2(lo, hi, c[1]);

`ifdef YMUX4TO1_REG_EN
    logic [SIZE-1:0] z_p1;

    // Stage p1: registered copy of the mux result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_p1 <= '0;
        end else begin
            z_p1 <= z;
        end
    end

    assign z_q = z_p1;
`else
    logic unused_clk_rst;

    assign unused_clk_rst = &{1'b0, clk, rst_n};
    assign z_q            = z;
`endif

endmodule

// File: tb/tb_y_mux_4to1.sv
// Scoreboard bench for y_mux_4to1: stimulus pushes expected z/z_q, a monitor pops and compares.
module tb_y_mux_4to1;

    typedef struct packed {
        logic [31:0] z;
        logic [31:0] zq;
        logic [7:0]  tag;
    } exp_t;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [31:0] w [4];
    logic [1:0]  c;
    logic [31:0] z;
    logic [31:0] z_q;
    logic [31:0] cap;

    exp_t exp_q[$];
    event sample_ev;
    int   total;
    int   bad;

    y_mux_4to1 #(.SIZE(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a0   (w[0]),
        .a1   (w[1]),
        .a2   (w[2]),
        .a3   (w[3]),
        .c    (c),
        .z    (z),
        .z_q  (z_q)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
            else        clk = 1'b0;
        end
    end

    // Monitor: samples 1 time unit after each stimulus change.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: no expected entry queued");
            end else begin
                e = exp_q.pop_front();
                total++;
                if (z !== e.z) begin
                    bad++;
                    $display("FAIL z tag=%0d c=%0d got=%h want=%h", e.tag, c, z, e.z);
                end
                total++;
                if (z_q !== e.zq) begin
                    bad++;
                    $display("FAIL z_q tag=%0d c=%0d got=%h want=%h", e.tag, c, z_q, e.zq);
                end
            end
        end
    end

    task automatic drive(input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] v3,
                         input logic [1:0] s);
        w[0] = v0;
        w[1] = v1;
        w[2] = v2;
        w[3] = v3;
        c    = s;
    endtask

    // Reference: the selected word is simply the array entry indexed by c.
    task automatic check(input int tag);
        exp_t e;
        e.z   = w[c];
`ifdef YMUX4TO1_REG_EN
        e.zq  = cap;
`else
        e.zq  = w[c];
`endif
        e.tag = 8'(tag);
        exp_q.push_back(e);
        ->sample_ev;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) cap = w[c];
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] s;
        total  = 0;
        bad    = 0;
        clk_en = 1'b1;
        rst_n  = 1'b0;
        cap    = '0;
        drive('0, '0, '0, '0, 2'd0);

        @(negedge clk);
        drive(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 2'd0);
        check(0);
        rst_n = 1'b1;
        step();
        for (int i = 1; i < 4; i++) begin
            c = 2'(i);
            check(i);
            step();
        end

        for (int i = 0; i < 10; i++) begin
            if (i == 0)      s = 2'd0;
            else if (i == 1) s = 2'd3;
            else             s = 2'($urandom_range(3));
            drive($urandom, $urandom, $urandom, $urandom, s);
            check(10 + i);
            step();
        end

        drive(32'hFFFFFFFF, '0, '0, '0, 2'd0);
        check(30);
        c = 2'd1;
        check(31);
        step();

        drive(32'hA5A5A5A5, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h5A5A5A5A, 2'd0);
        check(40);
        step();
        c = 2'd3;
        check(41);
        step();
        check(42);

        drive(32'h01234567, 32'h89ABCDEF, 32'h13579BDF, 32'h2468ACE0, 2'd1);
        check(50);
        rst_n = 1'b0;
        cap   = '0;
        check(51);
        step();
        check(52);
        rst_n = 1'b1;
        w[2]  = 32'hDEADBEEF;
        c     = 2'd2;
        check(53);
        step();
        check(54);

        clk_en = 1'b0;
        #12;
        for (int i = 0; i < 6; i++) begin
            drive($urandom, $urandom, $urandom, $urandom, 2'(i % 4));
            check(60 + i);
        end

        #5;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got=%0d want=0 entries left", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
